// File: rtl/traffic_pkg.sv
// Package: traffic_pkg
//   Shared types and constants for the traffic light controller.
//   - phase_t     : the seven controller phases
//   - LIGHT_*     : lamp encodings {red,yellow,green}
//   - lights_t    : main/side lamp pair
//   - decode_lights(): maps a phase (plus flash state) to the lamp pair
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN,
        MAIN_YELLOW,
        ALL_RED_1,
        SIDE_GREEN,
        SIDE_YELLOW,
        ALL_RED_2,
        FLASH
    } phase_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

    typedef struct packed {
        logic [2:0] main_light;
        logic [2:0] side_light;
    } lights_t;

    function automatic lights_t decode_lights(input phase_t phase, input logic flash_on);
        lights_t lights;
        lights.main_light = LIGHT_RED;
        lights.side_light = LIGHT_RED;
        case (phase)
            MAIN_GREEN:  lights.main_light = LIGHT_GREEN;
            MAIN_YELLOW: lights.main_light = LIGHT_YELLOW;
            SIDE_GREEN:  lights.side_light = LIGHT_GREEN;
            SIDE_YELLOW: lights.side_light = LIGHT_YELLOW;
            FLASH: begin
                lights.main_light = flash_on ? LIGHT_YELLOW : LIGHT_OFF;
                lights.side_light = flash_on ? LIGHT_YELLOW : LIGHT_OFF;
            end
            default: ;  // both all-red phases keep the red defaults
        endcase
        return lights;
    endfunction

endpackage

// File: rtl/traffic_light_controller_counter.sv
// Module: traffic_light_controller_counter
//   Free-running modulo counter used as the tick prescaler.
//   Ports:
//     clk_i      in  clock, rising edge
//     reset_n_i  in  asynchronous active-low reset (count returns to 0)
//     enable_i   in  count advances only while high; holds otherwise
//     carry_o    out high while the count sits at MODULUS-1 (terminal count)
module traffic_light_controller_counter #(
    parameter int unsigned MODULUS = 10,
    parameter int unsigned WIDTH   = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic enable_i,
    output logic carry_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    assign carry_o = (count_q == LAST);

endmodule

// File: rtl/traffic_light_controller.sv
// Module: traffic_light_controller
//   Phase sequencer for a main/side intersection with a pedestrian crossing.
//   A prescaler derives a slow tick; each timed phase counts down in ticks.
//   Main road rests in green until a latched side or pedestrian request is
//   pending and the minimum green time has elapsed. Emergency forces a
//   flashing-yellow phase from anywhere.
//   Ports:
//     clock_i        in  system clock, rising edge
//     reset_i        in  asynchronous active-high reset
//     enable_i       in  prescaler runs while high; timing frozen while low
//     side_sensor_i  in  side-road vehicle present (level or pulse)
//     ped_request_i  in  pedestrian button (pulse)
//     emergency_i    in  level; high forces FLASH
//     main_light_o   out main-road lamp {red,yellow,green}
//     side_light_o   out side-road lamp {red,yellow,green}
//     ped_walk_o     out walk signal, only during SIDE_GREEN
//     remaining_o    out ticks left in the current timed phase
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int unsigned tick_div         = 50_000_000,
    parameter int unsigned main_green_min   = 30,
    parameter int unsigned side_green_ticks = 20,
    parameter int unsigned yellow_ticks     = 3,
    parameter int unsigned all_red_ticks    = 2
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       side_sensor_i,
    input  logic       ped_request_i,
    input  logic       emergency_i,
    output logic [2:0] main_light_o,
    output logic [2:0] side_light_o,
    output logic       ped_walk_o,
    output logic [7:0] remaining_o
);

    generate
        if (tick_div < 2 ||
            main_green_min   < 1 || main_green_min   > 255 ||
            side_green_ticks < 1 || side_green_ticks > 255 ||
            yellow_ticks     < 1 || yellow_ticks     > 255 ||
            all_red_ticks    < 1 || all_red_ticks    > 255) begin : g_bad_params
            $error("traffic_light_controller: durations must be 1..255 and tick_div >= 2");
        end
    endgenerate

    localparam logic [7:0] MAIN_GREEN_TICKS = 8'(main_green_min);
    localparam logic [7:0] SIDE_GREEN_TICKS = 8'(side_green_ticks);
    localparam logic [7:0] YELLOW_TICKS     = 8'(yellow_ticks);
    localparam logic [7:0] ALL_RED_TICKS    = 8'(all_red_ticks);

    // ------------------------------------------------------------------
    // Tick prescaler
    // ------------------------------------------------------------------
    logic prescale_rst_n;
    logic prescale_carry;
    logic tick;

    assign prescale_rst_n = ~reset_i;

    traffic_light_controller_counter #(
        .MODULUS (tick_div)
    ) u_prescaler (
        .clk_i     (clock_i),
        .reset_n_i (prescale_rst_n),
        .enable_i  (enable_i),
        .carry_o   (prescale_carry)
    );

    // Carry alone stays high while the prescaler is frozen at terminal count.
    assign tick = prescale_carry & enable_i;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    phase_t     phase_q,     phase_d;
    logic [7:0] remaining_q, remaining_d;
    logic       side_req_q,  side_req_d;
    logic       ped_req_q,   ped_req_d;
    logic       flash_on_q,  flash_on_d;
    logic       ped_walk_q,  ped_walk_d;
    logic       enter_side;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q     <= ALL_RED_2;
            remaining_q <= ALL_RED_TICKS;
            side_req_q  <= 1'b0;
            ped_req_q   <= 1'b0;
            flash_on_q  <= 1'b0;
            ped_walk_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            side_req_q  <= side_req_d;
            ped_req_q   <= ped_req_d;
            flash_on_q  <= flash_on_d;
            ped_walk_q  <= ped_walk_d;
        end
    end

    // NOTE: every signal driven here is given a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        phase_d     = phase_q;
        remaining_d = remaining_q;
        flash_on_d  = flash_on_q;

        if (emergency_i) begin
            // Emergency bypasses the tick and enable: takes effect next edge.
            phase_d     = FLASH;
            remaining_d = 8'd0;
            if (phase_q != FLASH) begin
                flash_on_d = 1'b1;
            end else if (tick) begin
                flash_on_d = ~flash_on_q;
            end
        end else if (phase_q == FLASH) begin
            phase_d     = ALL_RED_2;
            remaining_d = ALL_RED_TICKS;
        end else if (tick) begin
            if (phase_q == MAIN_GREEN) begin
                if (remaining_q > 8'd1) begin
                    remaining_d = remaining_q - 8'd1;
                end else if (side_req_q || ped_req_q) begin
                    phase_d     = MAIN_YELLOW;
                    remaining_d = YELLOW_TICKS;
                end else begin
                    // Minimum green served, nobody waiting: rest at zero.
                    remaining_d = 8'd0;
                end
            end else if (remaining_q > 8'd1) begin
                remaining_d = remaining_q - 8'd1;
            end else begin
                case (phase_q)
                    MAIN_YELLOW: begin
                        phase_d     = ALL_RED_1;
                        remaining_d = ALL_RED_TICKS;
                    end
                    ALL_RED_1: begin
                        phase_d     = SIDE_GREEN;
                        remaining_d = SIDE_GREEN_TICKS;
                    end
                    SIDE_GREEN: begin
                        phase_d     = SIDE_YELLOW;
                        remaining_d = YELLOW_TICKS;
                    end
                    SIDE_YELLOW: begin
                        phase_d     = ALL_RED_2;
                        remaining_d = ALL_RED_TICKS;
                    end
                    default: begin  // ALL_RED_2
                        phase_d     = MAIN_GREEN;
                        remaining_d = MAIN_GREEN_TICKS;
                    end
                endcase
            end
        end

        enter_side = (phase_d == SIDE_GREEN) && (phase_q != SIDE_GREEN);

        // Requests are consumed on SIDE_GREEN entry; a request arriving in
        // that same cycle survives for the next cycle of service.
        side_req_d = side_sensor_i | (side_req_q & ~enter_side);
        ped_req_d  = ped_request_i | (ped_req_q  & ~enter_side);

        if (phase_d == SIDE_GREEN) begin
            ped_walk_d = enter_side ? ped_req_q : ped_walk_q;
        end else begin
            ped_walk_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    lights_t lights;

    assign lights       = decode_lights(phase_q, flash_on_q);
    assign main_light_o = lights.main_light;
    assign side_light_o = lights.side_light;
    assign ped_walk_o   = ped_walk_q;
    assign remaining_o  = remaining_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Testbench for traffic_light_controller with short durations:
// tick_div=2, main_green_min=4, side_green_ticks=3, yellow_ticks=2, all_red_ticks=1.
module tb_traffic_light_controller;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;

    typedef struct {
        int         n;       // cycles this record is held
        logic       side;
        logic       ped;
        logic       emg;
        logic       en;
        logic [2:0] exp_main;
        logic [2:0] exp_side;
        logic       exp_walk;
        logic [7:0] exp_rem;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       side_sensor;
    logic       ped_request;
    logic       emergency;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       ped_walk;
    logic [7:0] remaining;

    int n_vectors     = 0;
    int n_miscompares = 0;

    vec_t vec_q[$];

    traffic_light_controller #(
        .tick_div         (2),
        .main_green_min   (4),
        .side_green_ticks (3),
        .yellow_ticks     (2),
        .all_red_ticks    (1)
    ) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .enable_i      (enable),
        .side_sensor_i (side_sensor),
        .ped_request_i (ped_request),
        .emergency_i   (emergency),
        .main_light_o  (main_light),
        .side_light_o  (side_light),
        .ped_walk_o    (ped_walk),
        .remaining_o   (remaining)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic compare(input string name, input logic [2:0] em, input logic [2:0] es,
                           input logic ew, input logic [7:0] er);
        n_vectors++;
        if (main_light !== em || side_light !== es || ped_walk !== ew || remaining !== er) begin
            n_miscompares++;
            $display("FAIL %s: got main=%b side=%b walk=%b rem=%0d, want main=%b side=%b walk=%b rem=%0d",
                     name, main_light, side_light, ped_walk, remaining, em, es, ew, er);
        end
    endtask

    task automatic add(input int n, input logic s, input logic p, input logic e, input logic en,
                       input logic [2:0] em, input logic [2:0] es, input logic ew, input int er);
        vec_t v;
        v = '{n, s, p, e, en, em, es, ew, 8'(er)};
        vec_q.push_back(v);
    endtask

    // Hold the record's inputs for v.n edges, checking outputs 1 time unit after each edge.
    task automatic apply(input vec_t v, input string tag);
        side_sensor = v.side;
        ped_request = v.ped;
        emergency   = v.emg;
        enable      = v.en;
        for (int c = 0; c < v.n; c++) begin
            @(posedge clock);
            #1;
            compare($sformatf("%s cyc%0d", tag, c), v.exp_main, v.exp_side, v.exp_walk, v.exp_rem);
        end
    endtask

    task automatic run(input string tag, input int n, input logic s, input logic p, input logic e,
                       input logic en, input logic [2:0] em, input logic [2:0] es,
                       input logic ew, input int er);
        vec_t v;
        v = '{n, s, p, e, en, em, es, ew, 8'(er)};
        apply(v, tag);
    endtask

    // Assert reset between edges, check the asynchronous effect, hold across
    // one edge, then release 1 time unit after that edge.
    task automatic do_reset(input string tag);
        side_sensor = 1'b0;
        ped_request = 1'b0;
        emergency   = 1'b0;
        enable      = 1'b1;
        reset       = 1'b1;
        #2;
        compare({tag, " async"}, R, R, 1'b0, 8'd1);
        @(posedge clock);
        #1;
        compare({tag, " held"}, R, R, 1'b0, 8'd1);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        side_sensor = 1'b0;
        ped_request = 1'b0;
        emergency   = 1'b0;

        // ---- reset release, side cycle, long idle main green ----
        add(1,   0,0,0,1, R,R,0,1);
        add(2,   0,0,0,1, G,R,0,4);
        add(1,   1,0,0,1, G,R,0,3);   // side pulse on first main-green tick
        add(1,   0,0,0,1, G,R,0,3);
        add(2,   0,0,0,1, G,R,0,2);
        add(2,   0,0,0,1, G,R,0,1);
        add(2,   0,0,0,1, Y,R,0,2);
        add(2,   0,0,0,1, Y,R,0,1);
        add(2,   0,0,0,1, R,R,0,1);
        add(2,   0,0,0,1, R,G,0,3);
        add(2,   0,0,0,1, R,G,0,2);
        add(2,   0,0,0,1, R,G,0,1);
        add(2,   0,0,0,1, R,Y,0,2);
        add(2,   0,0,0,1, R,Y,0,1);
        add(2,   0,0,0,1, R,R,0,1);
        add(2,   0,0,0,1, G,R,0,4);
        add(2,   0,0,0,1, G,R,0,3);
        add(2,   0,0,0,1, G,R,0,2);
        add(2,   0,0,0,1, G,R,0,1);
        add(200, 0,0,0,1, G,R,0,0);   // no requests: rests at zero
        // ---- pedestrian during main yellow, re-request on side-green entry ----
        add(2,   1,0,0,1, G,R,0,0);
        add(1,   0,0,0,1, Y,R,0,2);
        add(1,   0,1,0,1, Y,R,0,2);
        add(2,   0,0,0,1, Y,R,0,1);
        add(2,   0,0,0,1, R,R,0,1);
        add(1,   0,1,0,1, R,G,1,3);   // new ped request in entry cycle
        add(1,   0,0,0,1, R,G,1,3);
        add(2,   0,0,0,1, R,G,1,2);
        add(2,   0,0,0,1, R,G,1,1);
        add(2,   0,0,0,1, R,Y,0,2);
        add(2,   0,0,0,1, R,Y,0,1);
        add(2,   0,0,0,1, R,R,0,1);
        add(2,   0,0,0,1, G,R,0,4);
        add(2,   0,0,0,1, G,R,0,3);
        add(2,   0,0,0,1, G,R,0,2);
        add(2,   0,0,0,1, G,R,0,1);
        add(2,   0,0,0,1, Y,R,0,2);   // kept request forces a second cycle
        add(2,   0,0,0,1, Y,R,0,1);
        add(2,   0,0,0,1, R,R,0,1);
        add(2,   0,0,0,1, R,G,1,3);
        add(2,   0,0,0,1, R,G,1,2);
        add(2,   0,0,0,1, R,G,1,1);
        add(2,   0,0,0,1, R,Y,0,2);
        add(2,   0,0,0,1, R,Y,0,1);
        add(2,   0,0,0,1, R,R,0,1);
        add(2,   0,0,0,1, G,R,0,4);
        add(2,   0,0,0,1, G,R,0,3);
        add(2,   0,0,0,1, G,R,0,2);
        add(2,   0,0,0,1, G,R,0,1);

        do_reset("power_on");
        for (int i = 0; i < vec_q.size(); i++) begin
            apply(vec_q[i], $sformatf("vec%0d", i));
        end

        // ---- emergency in the middle of a walk phase ----
        run("emg_idle",   1, 0,0,0,1, G,R,0,0);
        run("emg_req",    1, 1,1,0,1, G,R,0,0);
        run("emg_my2",    2, 0,0,0,1, Y,R,0,2);
        run("emg_my1",    2, 0,0,0,1, Y,R,0,1);
        run("emg_ar1",    2, 0,0,0,1, R,R,0,1);
        run("emg_sg3",    2, 0,0,0,1, R,G,1,3);
        run("emg_sg2",    2, 0,0,0,1, R,G,1,2);
        run("emg_enter",  1, 0,0,1,1, Y,Y,0,0);
        run("emg_latch",  1, 1,0,1,1, Y,Y,0,0);
        run("emg_off1",   2, 0,0,1,1, O,O,0,0);
        run("emg_on",     2, 0,0,1,1, Y,Y,0,0);
        run("emg_off2",   2, 0,0,1,1, O,O,0,0);
        run("emg_exit",   2, 0,0,0,1, R,R,0,1);
        run("emg_mg4",    2, 0,0,0,1, G,R,0,4);
        run("emg_mg3",    2, 0,0,0,1, G,R,0,3);
        run("emg_mg2",    2, 0,0,0,1, G,R,0,2);
        run("emg_mg1",    2, 0,0,0,1, G,R,0,1);
        run("emg_srv_my2",2, 0,0,0,1, Y,R,0,2);
        run("emg_srv_my1",2, 0,0,0,1, Y,R,0,1);
        run("emg_srv_ar1",2, 0,0,0,1, R,R,0,1);
        run("emg_srv_sg3",2, 0,0,0,1, R,G,0,3);
        run("emg_srv_sg2",2, 0,0,0,1, R,G,0,2);
        run("emg_srv_sg1",2, 0,0,0,1, R,G,0,1);
        run("emg_srv_sy2",2, 0,0,0,1, R,Y,0,2);
        run("emg_srv_sy1",2, 0,0,0,1, R,Y,0,1);
        run("emg_srv_ar2",2, 0,0,0,1, R,R,0,1);
        run("emg_srv_mg4",1, 0,0,0,1, G,R,0,4);

        // ---- enable freeze in main yellow, then reset mid side green ----
        run("frz_req",    1, 1,0,0,1, G,R,0,4);
        run("frz_mg3",    2, 0,0,0,1, G,R,0,3);
        run("frz_mg2",    2, 0,0,0,1, G,R,0,2);
        run("frz_mg1",    2, 0,0,0,1, G,R,0,1);
        run("frz_my2",    2, 0,0,0,1, Y,R,0,2);
        run("frz_hold",  50, 0,0,0,0, Y,R,0,2);
        run("frz_my1",    2, 0,0,0,1, Y,R,0,1);
        run("frz_ar1",    2, 0,0,0,1, R,R,0,1);
        run("frz_sg3a",   1, 0,0,0,1, R,G,0,3);
        run("frz_sg3b",   1, 1,1,0,1, R,G,0,3);   // latch both requests
        do_reset("mid_side_green");
        run("rst_ar2",    1, 0,0,0,1, R,R,0,1);
        run("rst_mg4",    2, 0,0,0,1, G,R,0,4);
        run("rst_mg3",    2, 0,0,0,1, G,R,0,3);
        run("rst_mg2",    2, 0,0,0,1, G,R,0,2);
        run("rst_mg1",    2, 0,0,0,1, G,R,0,1);
        run("rst_nolatch",4, 0,0,0,1, G,R,0,0);   // cleared latches: no advance

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
